// File: rtl/bcd_accumulator.sv
// Digit-serial BCD accumulator. Each 0..31 binary result is split into tens/ones
// and added into a 4-digit BCD total, one digit per clock, behind a valid/ready handshake.
module bcd_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_sum,
  input  logic        in_cout,
  output logic [15:0] total,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, D0, D1, D2, D3, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  v_q, v_d;
  logic        c_q, c_d;
  logic [15:0] total_q, total_d;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [3:0]  tens;
  logic [4:0]  tens_x10;
  logic [4:0]  ones_full;
  logic [3:0]  ones;
  logic [4:0]  step;

  // Returns {carry, digit}: one decimal digit position with incoming carry.
  function automatic logic [4:0] digit_add(input logic [3:0] digit,
                                           input logic [3:0] addend,
                                           input logic       cin);
    logic [4:0] s;
    s = {1'b0, digit} + {1'b0, addend} + {4'b0000, cin};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    else          return {1'b0, s[3:0]};
  endfunction

  always_comb begin
    tens     = 4'd0;
    tens_x10 = 5'd0;
    if (v_q >= 5'd30) begin
      tens     = 4'd3;
      tens_x10 = 5'd30;
    end else if (v_q >= 5'd20) begin
      tens     = 4'd2;
      tens_x10 = 5'd20;
    end else if (v_q >= 5'd10) begin
      tens     = 4'd1;
      tens_x10 = 5'd10;
    end
    ones_full = v_q - tens_x10;
    ones      = ones_full[3:0];
  end

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    c_d        = c_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    step       = 5'd0;
    in_ready   = (state_q == IDLE) && !clr && !rst;

    if (clr) begin
      state_d    = IDLE;
      c_d        = 1'b0;
      total_d    = 16'h0000;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            v_d     = {in_cout, in_sum};
            c_d     = 1'b0;
            state_d = D0;
          end
        end
        D0: begin
          step          = digit_add(total_q[3:0], ones, 1'b0);
          total_d[3:0]  = step[3:0];
          c_d           = step[4];
          state_d       = D1;
        end
        D1: begin
          step          = digit_add(total_q[7:4], tens, c_q);
          total_d[7:4]  = step[3:0];
          c_d           = step[4];
          state_d       = D2;
        end
        D2: begin
          step          = digit_add(total_q[11:8], 4'd0, c_q);
          total_d[11:8] = step[3:0];
          c_d           = step[4];
          state_d       = D3;
        end
        D3: begin
          // A carry out of the top digit means the total wrapped modulo 10000.
          step           = digit_add(total_q[15:12], 4'd0, c_q);
          total_d[15:12] = step[3:0];
          c_d            = step[4];
          if (step[4]) overflow_d = 1'b1;
          state_d        = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      v_q        <= 5'd0;
      c_q        <= 1'b0;
      total_q    <= 16'h0000;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      c_q        <= c_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign total    = total_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_accumulator.sv
// Directed bench for bcd_accumulator: a vector table of adds/clears with
// hand-computed BCD totals, plus sequences for reset, wrap, mid-op clear and hold.
module tb_bcd_accumulator;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, in_cout;
  logic [3:0]  in_sum;
  logic [15:0] total;
  logic        busy, done, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          do_clr;
    logic [4:0]  v;
    logic [15:0] exp_total;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  bcd_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_cout  (in_cout),
    .total    (total),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Offers v, waits for the handshake, then counts cycles until done.
  task automatic applyStimulus(input logic [4:0] v, input bit check_latency);
    int waited;
    int lat;
    waited = 0;
    lat    = 0;
    @(negedge clk);
    in_valid = 1'b1;
    {in_cout, in_sum} = v;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("handshake_timeout", 16'd0, 16'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (check_latency) checkOutput("latency", 16'(lat), 16'd4);
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int hs;
    int guard;
    bit seen_done;

    vecs[0]  = '{1'b0, 5'd15, 16'h0015, 1'b0};
    vecs[1]  = '{1'b1, 5'd0,  16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 5'd30, 16'h0030, 1'b0};
    vecs[3]  = '{1'b0, 5'd30, 16'h0060, 1'b0};
    vecs[4]  = '{1'b0, 5'd30, 16'h0090, 1'b0};
    vecs[5]  = '{1'b0, 5'd5,  16'h0095, 1'b0};
    vecs[6]  = '{1'b0, 5'd30, 16'h0125, 1'b0};
    vecs[7]  = '{1'b0, 5'd30, 16'h0155, 1'b0};
    vecs[8]  = '{1'b0, 5'd30, 16'h0185, 1'b0};
    vecs[9]  = '{1'b0, 5'd30, 16'h0215, 1'b0};
    vecs[10] = '{1'b0, 5'd30, 16'h0245, 1'b0};
    vecs[11] = '{1'b0, 5'd30, 16'h0275, 1'b0};
    vecs[12] = '{1'b0, 5'd25, 16'h0300, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  16'h0300, 1'b0};
    vecs[14] = '{1'b0, 5'd31, 16'h0331, 1'b0};
    vecs[15] = '{1'b0, 5'd9,  16'h0340, 1'b0};

    rst = 1'b1;
    clr = 1'b0;
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'd5;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_total", total, 16'h0000);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_done", {15'd0, done}, 16'd0);
    checkOutput("reset_overflow", {15'd0, overflow}, 16'd0);
    checkOutput("reset_in_ready", {15'd0, in_ready}, 16'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("ready_after_reset", {15'd0, in_ready}, 16'd1);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_clr) do_clear();
      else applyStimulus(vecs[i].v, 1'b1);
      checkOutput($sformatf("vec%0d_total", i), total, vecs[i].exp_total);
      checkOutput($sformatf("vec%0d_overflow", i), {15'd0, overflow}, {15'd0, vecs[i].exp_ovf});
      checkOutput($sformatf("vec%0d_busy", i), {15'd0, busy}, 16'd0);
    end

    do_clear();
    for (int i = 0; i < 333; i++) applyStimulus(5'd30, 1'b0);
    checkOutput("wrap_pre_total", total, 16'h9990);
    checkOutput("wrap_pre_overflow", {15'd0, overflow}, 16'd0);
    applyStimulus(5'd30, 1'b1);
    checkOutput("wrap_total", total, 16'h0020);
    checkOutput("wrap_overflow", {15'd0, overflow}, 16'd1);
    applyStimulus(5'd1, 1'b1);
    checkOutput("sticky_total", total, 16'h0021);
    checkOutput("sticky_overflow", {15'd0, overflow}, 16'd1);
    do_clear();
    checkOutput("clr_total", total, 16'h0000);
    checkOutput("clr_overflow", {15'd0, overflow}, 16'd0);

    do_clear();
    applyStimulus(5'd15, 1'b1);
    checkOutput("midclr_pre_total", total, 16'h0015);
    @(negedge clk);
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'd31;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("midclr_total", total, 16'h0000);
    checkOutput("midclr_busy", {15'd0, busy}, 16'd0);
    checkOutput("midclr_done", {15'd0, done}, 16'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    checkOutput("midclr_no_done", {15'd0, seen_done}, 16'd0);
    applyStimulus(5'd31, 1'b1);
    checkOutput("midclr_after_total", total, 16'h0031);

    do_clear();
    @(negedge clk);
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'd1;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) hs++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("hold_handshakes", 16'(hs), 16'd4);
    checkOutput("hold_total", total, 16'h0004);
    checkOutput("hold_busy", {15'd0, busy}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
